cp0_pending: RTL and testbench

Generates the 8-bit interrupt-pending vector `ip[7:0]` consumed by the CP0 interrupt-request stage, which masks it with IM/IE. The block owns the CP0 Count and Compare registers and the timer interrupt, synchronises the five external hardware interrupt lines, and holds the two software-interrupt bits written through MTC0 to Cause. It also provides a combinational MFC0 read path for the registers it owns.

---
 rtl/cp0_pending.sv | 135 +++++++++++++
 tb/tb_cp0_pending.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_pending.sv
// Purpose: builds the CP0 interrupt-pending vector (timer, synchronised hardware, software bits) plus the MFC0 read path for Count/Compare/Cause.
// Latency: hw_irq -> ip[6:2] two edges; MTC0 Cause -> ip[1:0] one edge; Count==Compare -> ip[7] one edge; rd_data is combinational.
// Backpressure: none; mtc0_we is a single-cycle strobe that is always accepted.
//
// Parameters: CNT_DIV (Count prescale, 1..16), COMPARE_RST (Compare reset value).
// Ports: clk, rst_n (async active-low); mtc0_we/mtc0_addr/mtc0_wdata (CP0 write);
//        rd_addr/rd_data (MFC0 read); hw_irq (async levels); ip (pending vector);
//        timer_irq_raw (copy of ip[7]).
// Build option: define CP0_TIMER_EN to include Count, Compare, the prescaler and
//        the timer interrupt; without it ip[7] is 0 and Count/Compare read as 0.

module cp0_pending #(
    parameter int unsigned CNT_DIV     = 2,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic [4:0]  hw_irq,
    output logic [7:0]  ip,
    output logic        timer_irq_raw
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;

    logic        wr_cause;
    logic [4:0]  hw_sync1;
    logic [4:0]  hw_sync2;
    logic [1:0]  sw_ip;
    logic        timer_bit;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;

    assign wr_cause = mtc0_we && (mtc0_addr == ADDR_CAUSE);

    // Two-flop synchroniser for the asynchronous hardware lines, plus the
    // software bits written through Cause[9:8].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_sync1 <= '0;
            hw_sync2 <= '0;
            sw_ip    <= '0;
        end else begin
            hw_sync1 <= hw_irq;
            hw_sync2 <= hw_sync1;
            if (wr_cause) begin
                sw_ip <= mtc0_wdata[9:8];
            end
        end
    end

`ifdef CP0_TIMER_EN
    // Wide enough for the largest legal divide (16 -> max pre value 15).
    localparam int unsigned    PRE_W    = 5;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CNT_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [31:0]      count;
    logic [31:0]      compare;
    logic             timer_ip;
    logic             wr_count;
    logic             wr_compare;
    logic             unused_wdata;

    assign wr_count     = mtc0_we && (mtc0_addr == ADDR_COUNT);
    assign wr_compare   = mtc0_we && (mtc0_addr == ADDR_COMPARE);
    assign unused_wdata = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre      <= '0;
            count    <= '0;
            compare  <= COMPARE_RST;
            timer_ip <= 1'b0;
        end else begin
            // A software write to Count replaces the increment and restarts
            // the prescale period.
            if (wr_count) begin
                count <= mtc0_wdata;
                pre   <= '0;
            end else if (pre == PRE_LAST) begin
                count <= count + 32'd1;
                pre   <= '0;
            end else begin
                pre <= pre + 1'b1;
            end

            if (wr_compare) begin
                compare <= mtc0_wdata;
            end

            // Match uses the registered Count/Compare. A Compare write is the
            // acknowledge and beats a coincident match; otherwise the bit holds.
            if (wr_compare) begin
                timer_ip <= 1'b0;
            end else if (count == compare) begin
                timer_ip <= 1'b1;
            end
        end
    end

    assign timer_bit  = timer_ip;
    assign count_rd   = count;
    assign compare_rd = compare;
`else
    // Only Cause[9:8] is consumed when the timer is absent.
    logic unused_wdata;
    assign unused_wdata = ^{mtc0_wdata[31:10], mtc0_wdata[7:0]};

    assign timer_bit  = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    assign ip            = {timer_bit, hw_sync2, sw_ip};
    assign timer_irq_raw = timer_bit;

    // Read path sees register outputs, so a same-cycle write reads old data.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_COUNT:   rd_data = count_rd;
            ADDR_COMPARE: rd_data = compare_rd;
            ADDR_CAUSE:   rd_data = {16'b0, ip, 8'b0};
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_pending.sv
module tb_cp0_pending;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  hw_irq;
    logic [7:0]  ip;
    logic        timer_irq_raw;

    cp0_pending #(
        .CNT_DIV     (2),
        .COMPARE_RST (32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mtc0_we       (mtc0_we),
        .mtc0_addr     (mtc0_addr),
        .mtc0_wdata    (mtc0_wdata),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .hw_irq        (hw_irq),
        .ip            (ip),
        .timer_irq_raw (timer_irq_raw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: at each falling edge, compare every expectation scheduled for
    // this cycle. ip checks also cover timer_irq_raw (bit 8 of the word).
    chk_t        cur;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            act = cur.is_rd ? rd_data : {23'b0, timer_irq_raw, ip};
            n_checks++;
            if (cur.cyc != cyc || act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, want %h (cycle %0d, due %0d)",
                         cur.name, act, cur.exp, cyc, cur.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_ip(input string name, input logic [7:0] v);
        chk_t e;
        e.cyc = cyc; e.is_rd = 1'b0; e.exp = {23'b0, v[7], v}; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_rd(input string name, input logic [4:0] a, input logic [31:0] v);
        chk_t e;
        rd_addr = a;
        e.cyc = cyc; e.is_rd = 1'b1; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mtc0_we    = 1'b1;
        mtc0_addr  = a;
        mtc0_wdata = d;
        step();
        mtc0_we    = 1'b0;
        mtc0_addr  = '0;
        mtc0_wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0;
        rd_addr = '0; hw_irq = '0;

        // Reset state
        step_n(2);
        expect_ip("rst_ip", 8'h00);
        expect_rd("rst_count", 5'd9, 32'h0);
        step();
        expect_rd("rst_compare", 5'd11, TIMER ? 32'hFFFF_FFFF : 32'h0);
        step();
        rst_n = 1'b1;

        // Compare = 10; same-cycle read returns the old Compare
        expect_ip("post_rst_ip", 8'h00);
        expect_rd("compare_old_on_write", 5'd11, TIMER ? 32'hFFFF_FFFF : 32'h0);
        wr(5'd11, 32'd10);                                   // edge 1
        expect_rd("compare_loaded", 5'd11, TIMER ? 32'd10 : 32'h0);
        expect_ip("no_match_yet", 8'h00);
        step_n(19);                                          // edge 20: Count = 10
        expect_ip("before_match", 8'h00);
        expect_rd("count_10", 5'd9, TIMER ? 32'd10 : 32'h0);
        step();                                              // edge 21
        expect_ip("timer_set", TIMER ? 8'h80 : 8'h00);
        step();                                              // edge 22
        expect_ip("timer_sticky", TIMER ? 8'h80 : 8'h00);
        expect_rd("count_11", 5'd9, TIMER ? 32'd11 : 32'h0);
        wr(5'd11, 32'd40);                                   // edge 23
        expect_ip("timer_cleared", 8'h00);

        // Software bits through Cause
        expect_rd("cause_old_on_write", 5'd13, 32'h0);
        wr(5'd13, 32'hFFFF_FF00 | 32'h0000_0300 & 32'h0000_0300); // edge 24
        expect_ip("sw_bits", 8'h03);
        expect_rd("cause_sw", 5'd13, 32'h0000_0300);

        // Hardware synchroniser
        hw_irq = 5'b10001;
        step();                                              // edge 25
        expect_ip("hw_one_edge", 8'h03);
        expect_rd("compare_40", 5'd11, TIMER ? 32'd40 : 32'h0);
        step();                                              // edge 26
        expect_ip("hw_two_edges", 8'h47);
        expect_rd("cause_hw", 5'd13, 32'h0000_4700);
        hw_irq = 5'b00000;
        step();                                              // edge 27
        expect_ip("hw_drop_one_edge", 8'h47);
        step();                                              // edge 28
        expect_ip("hw_drop_two_edges", 8'h03);

        // Same-cycle Compare write beats a match
        wr(5'd9, 32'd40);                                    // edge 29
        expect_ip("count_eq_compare", 8'h03);
        expect_rd("count_written", 5'd9, TIMER ? 32'd40 : 32'h0);
        wr(5'd11, 32'd100);                                  // edge 30: match + write
        expect_ip("clear_wins", 8'h03);
        expect_rd("compare_100", 5'd11, TIMER ? 32'd100 : 32'h0);
        step();                                              // edge 31
        expect_rd("count_41", 5'd9, TIMER ? 32'd41 : 32'h0);

        // Wrap-around and write priority
        wr(5'd9, 32'hFFFF_FFFE);                             // edge 32
        expect_rd("wrap_fffe_a", 5'd9, TIMER ? 32'hFFFF_FFFE : 32'h0);
        step();                                              // edge 33
        expect_rd("wrap_fffe_b", 5'd9, TIMER ? 32'hFFFF_FFFE : 32'h0);
        step();                                              // edge 34
        expect_rd("wrap_ffff", 5'd9, TIMER ? 32'hFFFF_FFFF : 32'h0);
        step_n(2);                                           // edge 36
        expect_rd("wrap_zero", 5'd9, 32'h0);
        step();                                              // edge 37: prescaler at last
        wr(5'd9, 32'd5);                                     // edge 38: wrap cycle
        expect_rd("write_beats_inc", 5'd9, TIMER ? 32'd5 : 32'h0);
        step_n(2);                                           // edge 40
        expect_rd("count_after_write", 5'd9, TIMER ? 32'd6 : 32'h0);
        expect_ip("ip_before_rst", 8'h03);

        // Asynchronous reset mid-cycle
        step();
        rst_n = 1'b0;
        #1;
        expect_ip("async_rst_ip", 8'h00);
        expect_rd("async_rst_count", 5'd9, 32'h0);
        step();
        expect_rd("async_rst_compare", 5'd11, TIMER ? 32'hFFFF_FFFF : 32'h0);
        step();
        rst_n = 1'b1;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
